// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector through a combinational gate and checks Y against EXPECT.
// A sweep takes 2^N_IN*(SETTLE+1) cycles. Results hold until the next start.
module gate_truth_table_checker #(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 1,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fail_vld_q, fail_vld_d;
  logic [N_IN-1:0] first_q, first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      first_q    <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    first_d    = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d      = '0;
          cnt_d      = CNT_INIT;
          err_d      = '0;
          fail_vld_d = 1'b0;
          first_d    = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // y_in is only looked at here, after the vector has settled
          if (y_in != EXPECT[vec_q]) begin
            err_d = err_q + ERR_ONE;
            if (!fail_vld_q) begin
              first_d    = vec_q;
              fail_vld_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + VEC_ONE;
            cnt_d = CNT_INIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_out        = vec_q;
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign fail_valid     = fail_vld_q;
  assign first_fail_vec = first_q;

endmodule
